rv32_m_data_memory_responder: RTL and testbench
===============================================

RV32_M_DATA_MEMORY_RESPONDER -- requirements
Module: rv32_m_data_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the memory array (power of two, 2..65536).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port req_valid_i, input, 1, request present.
REQ-005 SHALL have port req_ready_o, output, 1, responder can accept a request this cycle.
REQ-006 SHALL have port req_be_i, input, 4, byte write enables as produced by the datapath-side memory controller; 4'b0000 = load.
REQ-007 SHALL have port req_addr_i, input, 32, byte address; only bits [31:2] used, bits [1:0] ignored.
REQ-008 SHALL have port req_wdata_i, input, 32, lane-aligned store data.
REQ-009 SHALL have port rsp_valid_o, input-facing output, 1, response present.
REQ-010 SHALL have port rsp_ready_i, input, 1, consumer accepts response.
REQ-011 SHALL have port rsp_rdata_o, output, 32, full read word (loads); 32'h0 for stores and errors.
REQ-012 SHALL have port rsp_error_o, output, 1, access fault: word index req_addr_i[31:2] >= DEPTH_WORDS.

Function
REQ-013 Request handshake SHALL fire when req_valid_i && req_ready_o at a rising edge with rst_i low; no other cycle has effect on memory or queue.
REQ-014 req_ready_o SHALL equal (queue count != 2), with no combinational dependence on rsp_ready_i or req_valid_i.
REQ-015 Response queue SHALL be a 2-entry FIFO (count 0..2, 1-bit read/write pointers, wrap 1->0) of {rdata, error}.
REQ-016 On a fired load in range: memory word read at the firing edge and pushed to the queue at that same edge; response visible the next cycle (latency 1).
REQ-017 On a fired store in range: each byte lane k with req_be_i[k]=1 SHALL be written with req_wdata_i[8k+7:8k]; other lanes unchanged; response pushed with rdata 32'h0, error 0.
REQ-018 Any request (load or store) out of range SHALL NOT modify memory and SHALL push rdata 32'h0, error 1.
REQ-019 Read of a word written in an earlier cycle SHALL return the new data; there is no same-cycle read/write of one word (one request per cycle).
REQ-020 rsp_valid_o SHALL equal (count != 0); rsp_rdata_o/rsp_error_o SHALL reflect the head entry and stay stable while rsp_valid_o && !rsp_ready_i.
REQ-021 Pop SHALL occur when rsp_valid_o && rsp_ready_i; simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 Responses SHALL be returned strictly in request order.
REQ-023 With count=2, no request fires even if rsp_ready_i=1 that cycle; acceptance resumes the cycle after the pop.
REQ-024 Sustained throughput SHALL be one request per cycle while rsp_ready_i is held high.

Reset
REQ-025 While rst_i high at an edge: count, pointers cleared; rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, req_ready_o=1 the following cycle.
REQ-026 Request presented in a reset cycle SHALL NOT write memory and SHALL NOT be queued; pending responses at reset are discarded.
REQ-027 Memory array contents SHALL NOT be cleared by reset.

Verification
REQ-028 Store be=4'b1111 addr 0x10 wdata 0xDEADBEEF, then load addr 0x10 -> load response rdata 0xDEADBEEF, error 0, one cycle after its acceptance.
REQ-029 After REQ-028, store be=4'b0100 addr 0x12 wdata 0x00AB0000, load addr 0x10 -> rdata 0xDEABBEEF.
REQ-030 DEPTH_WORDS=1024, store addr 0x1000 be=4'b1111 -> error 1, rdata 0; subsequent load addr 0x1000 -> error 1; word 0 unchanged.
REQ-031 rsp_ready_i=0, three back-to-back loads -> first two accepted, req_ready_o=0 from next cycle; raise rsp_ready_i -> third accepted the cycle after first pop; three responses in order.
REQ-032 Load accepted, rst_i asserted one cycle before rsp_ready_i -> response never appears, rsp_valid_o=0, req_ready_o=1 after reset.
REQ-033 rsp_ready_i=1, loads on 8 consecutive cycles to addrs 0x0..0x1C -> 8 responses on 8 consecutive cycles, req_ready_o never low.

Source files
------------

// File: rtl/rv32_m_data_memory_responder.sv
// rv32_m_data_memory_responder: word-addressed data memory with a 2-entry in-order response queue
// clk_i/rst_i       : clock, synchronous active-high reset
// req_*             : valid/ready request; be=0 load, else byte-lane store; addr[31:2] selects word
// rsp_*             : valid/ready response carrying {rdata, error}; rdata is 0 for stores/faults
module rv32_m_data_memory_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic in_range, fire, pop, unused_addr;
  logic [31:0] push_rdata;
  logic [1:0] cnt_q, cnt_d;
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0][31:0] q_rdata_q, q_rdata_d;
  logic [1:0] q_err_q, q_err_d;
  assign unused_addr = ^req_addr_i[1:0];
  assign idx = req_addr_i[AW+1:2];
  assign in_range = {2'b00, req_addr_i[31:2]} < 32'(DEPTH_WORDS);
  assign req_ready_o = cnt_q != 2'd2;
  assign fire = req_valid_i && req_ready_o && !rst_i;
  assign rsp_valid_o = cnt_q != 2'd0;
  assign pop = rsp_valid_o && rsp_ready_i;
  assign push_rdata = (req_be_i == 4'b0000 && in_range) ? mem[idx] : 32'h0;
  // head is masked while empty so stale entries never leak out after reset
  assign rsp_rdata_o = rsp_valid_o ? q_rdata_q[rd_ptr_q] : 32'h0;
  assign rsp_error_o = rsp_valid_o && q_err_q[rd_ptr_q];
  always_comb begin
    cnt_d = cnt_q + {1'b0, fire} - {1'b0, pop};
    wr_ptr_d = wr_ptr_q ^ fire;
    rd_ptr_d = rd_ptr_q ^ pop;
    q_rdata_d = q_rdata_q;
    q_err_d = q_err_q;
    if (fire) begin
      q_rdata_d[wr_ptr_q] = push_rdata;
      q_err_d[wr_ptr_q] = !in_range;
    end
  end
  always_ff @(posedge clk_i) begin
    q_rdata_q <= q_rdata_d;
    q_err_q <= q_err_d;
    if (rst_i) begin
      cnt_q <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (fire && in_range)
      for (int k = 0; k < 4; k++)
        if (req_be_i[k]) mem[idx][8*k +: 8] <= req_wdata_i[8*k +: 8];
  end
endmodule

// File: tb/tb_rv32_m_data_memory_responder.sv
// tb_rv32_m_data_memory_responder: directed self-checking bench for the data memory responder
module tb_rv32_m_data_memory_responder;
  logic clk_i = 1'b0;
  logic rst_i, req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i, rsp_error_o;
  logic [3:0] req_be_i;
  logic [31:0] req_addr_i, req_wdata_i, rsp_rdata_o;
  int n_pass = 0;
  int n_total = 0;
  rv32_m_data_memory_responder #(.DEPTH_WORDS(1024)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_be_i(req_be_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic req(input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i = 1'b1;
    req_be_i = be;
    req_addr_i = addr;
    req_wdata_i = wdata;
  endtask
  task automatic idle();
    req_valid_i = 1'b0;
    req_be_i = 4'b0;
    req_addr_i = 32'h0;
    req_wdata_i = 32'h0;
  endtask
  initial begin
    logic [31:0] exp_word [8];
    rst_i = 1'b1;
    rsp_ready_i = 1'b1;
    idle();
    tick();
    tick();
    rst_i = 1'b0;
    chk("reset_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("reset_rdata", rsp_rdata_o, 32'h0);
    chk("reset_error", {31'b0, rsp_error_o}, 32'd0);
    chk("reset_ready", {31'b0, req_ready_o}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      req(4'hF, 32'(i * 4), 32'hA000_0000 + 32'(i));
      tick();
      chk("preload_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
      chk("preload_rsp_rdata", rsp_rdata_o, 32'h0);
    end
    idle();
    tick();
    chk("preload_drained", {31'b0, rsp_valid_o}, 32'd0);
    req(4'hF, 32'h10, 32'hDEAD_BEEF);
    tick();
    chk("st_full_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("st_full_rdata", rsp_rdata_o, 32'h0);
    chk("st_full_error", {31'b0, rsp_error_o}, 32'd0);
    req(4'h0, 32'h10, 32'h0);
    tick();
    chk("ld_full_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("ld_full_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
    chk("ld_full_error", {31'b0, rsp_error_o}, 32'd0);
    req(4'b0100, 32'h12, 32'h00AB_0000);
    tick();
    chk("st_lane2_error", {31'b0, rsp_error_o}, 32'd0);
    req(4'h0, 32'h10, 32'h0);
    tick();
    chk("ld_lane2_rdata", rsp_rdata_o, 32'hDEAB_BEEF);
    req(4'hF, 32'h1000, 32'h1234_5678);
    tick();
    chk("st_oob_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("st_oob_error", {31'b0, rsp_error_o}, 32'd1);
    chk("st_oob_rdata", rsp_rdata_o, 32'h0);
    req(4'h0, 32'h1000, 32'h0);
    tick();
    chk("ld_oob_error", {31'b0, rsp_error_o}, 32'd1);
    chk("ld_oob_rdata", rsp_rdata_o, 32'h0);
    req(4'h0, 32'h0, 32'h0);
    tick();
    chk("word0_intact", rsp_rdata_o, 32'hA000_0000);
    chk("word0_error", {31'b0, rsp_error_o}, 32'd0);
    idle();
    tick();
    rsp_ready_i = 1'b0;
    req(4'h0, 32'h4, 32'h0);
    tick();
    chk("bp_ready_after_1", {31'b0, req_ready_o}, 32'd1);
    req(4'h0, 32'h8, 32'h0);
    tick();
    chk("bp_full_ready", {31'b0, req_ready_o}, 32'd0);
    chk("bp_head_first", rsp_rdata_o, 32'hA000_0001);
    req(4'h0, 32'hC, 32'h0);
    tick();
    chk("bp_held_ready", {31'b0, req_ready_o}, 32'd0);
    chk("bp_head_stable", rsp_rdata_o, 32'hA000_0001);
    rsp_ready_i = 1'b1;
    chk("bp_ready_no_comb", {31'b0, req_ready_o}, 32'd0);
    tick();
    chk("bp_after_pop_ready", {31'b0, req_ready_o}, 32'd1);
    chk("bp_second_rsp", rsp_rdata_o, 32'hA000_0002);
    tick();
    idle();
    chk("bp_third_rsp", rsp_rdata_o, 32'hA000_0003);
    chk("bp_third_valid", {31'b0, rsp_valid_o}, 32'd1);
    tick();
    chk("bp_drained", {31'b0, rsp_valid_o}, 32'd0);
    rsp_ready_i = 1'b0;
    req(4'h0, 32'h14, 32'h0);
    tick();
    chk("rst_pending_valid", {31'b0, rsp_valid_o}, 32'd1);
    rst_i = 1'b1;
    req(4'hF, 32'h18, 32'hFFFF_FFFF);
    tick();
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    idle();
    chk("rst_discard_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_discard_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_discard_rdata", rsp_rdata_o, 32'h0);
    tick();
    chk("rst_no_queue", {31'b0, rsp_valid_o}, 32'd0);
    for (int i = 0; i < 8; i++) exp_word[i] = 32'hA000_0000 + 32'(i);
    exp_word[4] = 32'hDEAB_BEEF;
    for (int i = 0; i < 8; i++) begin
      req(4'h0, 32'(i * 4), 32'h0);
      chk("stream_ready", {31'b0, req_ready_o}, 32'd1);
      tick();
      chk("stream_valid", {31'b0, rsp_valid_o}, 32'd1);
      chk("stream_rdata", rsp_rdata_o, exp_word[i]);
    end
    idle();
    tick();
    chk("stream_drained", {31'b0, rsp_valid_o}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
